// File: rtl/vrf_pkg.sv
// vrf_pkg: shared clear-FSM state type and default sizing for the vector register file
package vrf_pkg;
    localparam int DEFAULT_LANE_BITS       = 32;
    localparam int DEFAULT_LANES           = 4;
    localparam int DEFAULT_ADDR_NUMBER     = 5;
    localparam int DEFAULT_REGISTER_NUMBER = 16;
    typedef enum logic {IDLE, CLEAR} clear_state_t;
endpackage

// File: rtl/vrf_clear_sequencer.sv
// vrf_clear_sequencer: walks every register row once after a clear request
module vrf_clear_sequencer
    import vrf_pkg::*;
#(
    parameter int REGISTER_NUMBER = DEFAULT_REGISTER_NUMBER,
    parameter int ADDR_NUMBER     = DEFAULT_ADDR_NUMBER
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear_req,
    output logic                   clear_busy,
    output logic [ADDR_NUMBER-1:0] clear_row,
    output logic                   clear_row_valid
);
    localparam logic [ADDR_NUMBER-1:0] LAST_ROW = ADDR_NUMBER'(REGISTER_NUMBER - 1);
    clear_state_t state, state_nxt;
    logic [ADDR_NUMBER-1:0] row, row_nxt;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            row   <= '0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
        end
    end
    always_comb begin
        state_nxt = (state == IDLE) ? (clear_req ? CLEAR : IDLE) : (row == LAST_ROW ? IDLE : CLEAR);
        row_nxt   = (state == IDLE || row == LAST_ROW) ? '0 : row + ADDR_NUMBER'(1);
    end
    assign clear_busy      = (state == CLEAR);
    assign clear_row       = row;
    assign clear_row_valid = (state == CLEAR);
endmodule

// File: rtl/vector_register_file.sv
// vector_register_file: lane-masked register file with bypassed registered reads, pending scoreboard and sweep-clear
module vector_register_file
    import vrf_pkg::*;
#(
    parameter int LANE_BITS       = DEFAULT_LANE_BITS,
    parameter int LANES           = DEFAULT_LANES,
    parameter int ADDR_NUMBER     = DEFAULT_ADDR_NUMBER,
    parameter int REGISTER_NUMBER = DEFAULT_REGISTER_NUMBER
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write_enable,
    input  logic [ADDR_NUMBER-1:0]       dest_addr,
    input  logic [LANES*LANE_BITS-1:0]   write_data,
    input  logic [LANES-1:0]             write_mask,
    input  logic [ADDR_NUMBER-1:0]       src_addr_1,
    input  logic [ADDR_NUMBER-1:0]       src_addr_2,
    output logic [LANES*LANE_BITS-1:0]   data_out_1,
    output logic [LANES*LANE_BITS-1:0]   data_out_2,
    output logic                         pending_1,
    output logic                         pending_2,
    input  logic                         reserve_enable,
    input  logic [ADDR_NUMBER-1:0]       reserve_addr,
    input  logic                         clear_req,
    output logic                         clear_busy
);
    localparam int W = LANES * LANE_BITS;
    logic [W-1:0] regs    [REGISTER_NUMBER];
    logic [W-1:0] reg_nxt [REGISTER_NUMBER];
    logic [REGISTER_NUMBER-1:0] pend, pend_nxt;
    logic [W-1:0] bit_mask, rd_1, rd_2;
    logic rp_1, rp_2, wr_ok, rs_ok, clear_row_valid;
    logic [ADDR_NUMBER-1:0] clear_row;
    vrf_clear_sequencer #(
        .REGISTER_NUMBER(REGISTER_NUMBER),
        .ADDR_NUMBER(ADDR_NUMBER)
    ) u_clear (
        .clk(clk),
        .reset(reset),
        .clear_req(clear_req),
        .clear_busy(clear_busy),
        .clear_row(clear_row),
        .clear_row_valid(clear_row_valid)
    );
    assign wr_ok = write_enable && !clear_busy;
    assign rs_ok = reserve_enable && !clear_busy;
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign bit_mask[l*LANE_BITS +: LANE_BITS] = {LANE_BITS{write_mask[l]}};
    end
    // Out-of-range addresses match no row, so they never touch state.
    for (genvar r = 0; r < REGISTER_NUMBER; r++) begin : g_row
        logic hit_w, hit_r, hit_c;
        assign hit_w       = wr_ok && dest_addr == ADDR_NUMBER'(r);
        assign hit_r       = rs_ok && reserve_addr == ADDR_NUMBER'(r);
        assign hit_c       = clear_row_valid && clear_row == ADDR_NUMBER'(r);
        assign reg_nxt[r]  = hit_c ? '0 : hit_w ? (write_data & bit_mask) | (regs[r] & ~bit_mask) : regs[r];
        assign pend_nxt[r] = !hit_c && (hit_r || (pend[r] && !hit_w));
    end
    // Reads select the next-state row, which gives write bypass and same-cycle scoreboard updates.
    always_comb begin
        rd_1 = '0;
        rd_2 = '0;
        rp_1 = 1'b0;
        rp_2 = 1'b0;
        for (int i = 0; i < REGISTER_NUMBER; i++) begin
            if (src_addr_1 == ADDR_NUMBER'(i)) begin
                rd_1 = reg_nxt[i];
                rp_1 = pend_nxt[i];
            end
            if (src_addr_2 == ADDR_NUMBER'(i)) begin
                rd_2 = reg_nxt[i];
                rp_2 = pend_nxt[i];
            end
        end
    end
    always_ff @(posedge clk) begin
        for (int r = 0; r < REGISTER_NUMBER; r++)
            regs[r] <= reset ? '0 : reg_nxt[r];
        pend       <= reset ? '0 : pend_nxt;
        data_out_1 <= reset ? '0 : rd_1;
        data_out_2 <= reset ? '0 : rd_2;
        pending_1  <= reset ? 1'b0 : rp_1;
        pending_2  <= reset ? 1'b0 : rp_2;
    end
endmodule
